multi_channel_fifo_queue: RTL

//  NUM_CHANNELS independent circular FIFOs sharing one registered output port, drained in round-robin order.

---
 rtl/multi_channel_fifo_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/multi_channel_fifo_queue.sv
// NUM_CHANNELS circular FIFOs with per-channel request/ack push, drained round-robin into one registered output.
// Optional feature macro: MULTI_CHANNEL_FIFO_OCCUPANCY_EN exposes per-channel counts on occupancy_out.
module multi_channel_fifo_queue #(
    parameter int NUM_CHANNELS               = 4,
    parameter int CHANNEL_ID_WIDTH_IN_BITS   = 2,
    parameter int QUEUE_SIZE                 = 16,
    parameter int QUEUE_PTR_WIDTH_IN_BITS    = 4,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32,
    parameter int ALMOST_FULL_THRESHOLD      = 12
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [NUM_CHANNELS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
    input  logic [NUM_CHANNELS-1:0]                             request_valid_in,
    output logic [NUM_CHANNELS-1:0]                             issue_ack_out,
    output logic [NUM_CHANNELS-1:0]                             is_empty_out,
    output logic [NUM_CHANNELS-1:0]                             is_full_out,
    output logic [NUM_CHANNELS-1:0]                             is_almost_full_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               request_out,
    output logic [CHANNEL_ID_WIDTH_IN_BITS-1:0]                 request_channel_out,
    output logic                                                request_valid_out,
    input  logic                                                issue_ack_in
`ifdef MULTI_CHANNEL_FIFO_OCCUPANCY_EN
    ,
    output logic [NUM_CHANNELS*(QUEUE_PTR_WIDTH_IN_BITS+1)-1:0] occupancy_out
`endif
);
    localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int P = QUEUE_PTR_WIDTH_IN_BITS;
    localparam int C = CHANNEL_ID_WIDTH_IN_BITS;

    logic [W-1:0]            r_mem [NUM_CHANNELS][QUEUE_SIZE];
    logic [P-1:0]            r_wr_ptr [NUM_CHANNELS];
    logic [P-1:0]            r_rd_ptr [NUM_CHANNELS];
    logic [P:0]              r_count  [NUM_CHANNELS];
    logic [C-1:0]            r_rr_last;
    logic [W-1:0]            r_request_data;
    logic [C-1:0]            r_request_channel;
    logic                    r_request_valid;

    logic [NUM_CHANNELS-1:0] w_push;
    logic [NUM_CHANNELS-1:0] w_pop;
    logic                    w_load_en;
    logic                    w_grant_found;
    logic [C-1:0]            w_grant;
    logic [W-1:0]            w_head;

    // Handshakes: a push on channel i happens on any edge where request_valid_in[i] & issue_ack_out[i];
    // the output entry is consumed on any edge where request_valid_out & issue_ack_in, and is held otherwise.
    assign w_load_en = ~r_request_valid | issue_ack_in;
    assign w_push    = issue_ack_out;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        assign is_empty_out[g]       = (r_count[g] == '0);
        assign is_full_out[g]        = (r_count[g] == (P+1)'(QUEUE_SIZE));
        assign is_almost_full_out[g] = (r_count[g] >= (P+1)'(ALMOST_FULL_THRESHOLD));
        assign issue_ack_out[g]      = request_valid_in[g] & ~is_full_out[g];
        assign w_pop[g]              = w_load_en & w_grant_found & (w_grant == C'(g));
`ifdef MULTI_CHANNEL_FIFO_OCCUPANCY_EN
        assign occupancy_out[g*(P+1) +: (P+1)] = r_count[g];
`endif
        a_count_bound: assert property (@(posedge clk_in) disable iff (reset_in)
            r_count[g] <= (P+1)'(QUEUE_SIZE));
    end

    // Search starts just after the last granted channel, so every non-empty channel is served in turn.
    always_comb begin
        int idx;
        idx           = 0;
        w_grant_found = 1'b0;
        w_grant       = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            idx = (int'(r_rr_last) + k) % NUM_CHANNELS;
            if (!w_grant_found && !is_empty_out[C'(idx)]) begin
                w_grant_found = 1'b1;
                w_grant       = C'(idx);
            end
        end
    end

    assign w_head = r_mem[w_grant][r_rd_ptr[w_grant]];

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_last         <= C'(NUM_CHANNELS - 1);
            r_request_valid   <= 1'b0;
            r_request_data    <= '0;
            r_request_channel <= '0;
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_count[i] <= r_count[i] + 1'b1;
                end else if (!w_push[i] && w_pop[i]) begin
                    r_count[i] <= r_count[i] - 1'b1;
                end
            end
            if (w_load_en) begin
                r_request_valid <= w_grant_found;
                if (w_grant_found) begin
                    r_request_data    <= w_head;
                    r_request_channel <= w_grant;
                    r_rr_last         <= w_grant;
                end
            end
        end
    end

    // Storage is deliberately left out of reset; pointers alone define what is valid.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= request_in[i*W +: W];
            end
        end
    end

    assign request_out         = r_request_data;
    assign request_channel_out = r_request_channel;
    assign request_valid_out   = r_request_valid;

endmodule
